// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions: register-file geometry and the decoded-operand bundle
// exchanged between decode and the hazard scoreboard.
package reg_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ADDR_W     = REG_ADDR_W;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned SB_CNT_W   = 2;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t rs1;
        logic      rs1_used;
        reg_addr_t rs2;
        logic      rs2_used;
        reg_addr_t rd;
        logic      rd_we;
    } operand_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/kill bus between the decode stage (master) and the scoreboard (slave).
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic                  issue_valid;
    reg_addr_t             issue_rs1;
    logic                  issue_rs1_used;
    reg_addr_t             issue_rs2;
    logic                  issue_rs2_used;
    reg_addr_t             issue_rd;
    logic                  issue_rd_we;
    logic                  issue_accept;
    logic                  stall;
    logic                  wb_valid;
    reg_addr_t             wb_rd;
    logic                  kill_valid;
    reg_addr_t             kill_rd;
    logic [NUM_REGS-1:0]   busy_mask;
    logic                  sb_error;

    modport master (
        output issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
        output issue_rd, issue_rd_we, wb_valid, wb_rd, kill_valid, kill_rd,
        input  issue_accept, stall, busy_mask, sb_error
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
        input  issue_rd, issue_rd_we, wb_valid, wb_rd, kill_valid, kill_rd,
        output issue_accept, stall, busy_mask, sb_error
    );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register: net +inc -dec -kill per cycle,
// clamped at zero (flagging underflow) and saturating at the top.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             kill,
    output logic [CNT_W-1:0] count_q,
    output logic             busy_q,
    output logic             underflow_c
);

    // One sign bit plus one headroom bit above the counter range.
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [SUM_W-1:0] sum_c;
    logic [CNT_W-1:0] count_d;
    logic             busy_d;

    always_comb begin
        count_d     = count_q;
        underflow_c = 1'b0;
        sum_c       = SUM_W'(count_q) + SUM_W'(inc) - SUM_W'(dec) - SUM_W'(kill);
        if (sum_c[SUM_W-1]) begin
            count_d     = '0;
            underflow_c = 1'b1;
        end else if (sum_c > SUM_MAX) begin
            count_d = '1;
        end else begin
            count_d = sum_c[CNT_W-1:0];
        end
        busy_d = (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard: counts in-flight writes per register and holds decode
// while a source is still pending or the destination counter is full.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic            clock,
    input  logic            reset,
    reg_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    operand_t            op;
    logic [CNT_W-1:0]    count [NUM_REGS];
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] kill_hit;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] underflow;
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    cnt_rs1;
    logic [CNT_W-1:0]    cnt_rs2;
    logic [CNT_W-1:0]    cnt_rd;
    logic                rs1_hazard;
    logic                rs2_hazard;
    logic                sat_hazard;
    logic                accept;
    logic                sb_error_q;
    logic                sb_error_d;

    assign op = '{rs1: sb.issue_rs1, rs1_used: sb.issue_rs1_used,
                  rs2: sb.issue_rs2, rs2_used: sb.issue_rs2_used,
                  rd:  sb.issue_rd,  rd_we:    sb.issue_rd_we};

    // Writes and kills aimed at register 0 are dropped here.
    always_comb begin
        wb_hit   = '0;
        kill_hit = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            wb_hit[r]   = sb.wb_valid   && (sb.wb_rd   == REG_ADDR_W'(r));
            kill_hit[r] = sb.kill_valid && (sb.kill_rd == REG_ADDR_W'(r));
        end
    end

    // A writeback this cycle reaches the falling-edge read, so it retires one pending write;
    // a kill does not, since the squashed result never lands in the file.
    always_comb begin
        cnt_rs1    = count[op.rs1];
        cnt_rs2    = count[op.rs2];
        cnt_rd     = count[op.rd];
        rs1_hazard = op.rs1_used && (op.rs1 != ZERO_REG) &&
                     ((cnt_rs1 > CNT_ONE) || ((cnt_rs1 == CNT_ONE) && !wb_hit[op.rs1]));
        rs2_hazard = op.rs2_used && (op.rs2 != ZERO_REG) &&
                     ((cnt_rs2 > CNT_ONE) || ((cnt_rs2 == CNT_ONE) && !wb_hit[op.rs2]));
        sat_hazard = op.rd_we && (op.rd != ZERO_REG) &&
                     (cnt_rd == CNT_MAX) && !wb_hit[op.rd];
        accept     = sb.issue_valid && !rs1_hazard && !rs2_hazard && !sat_hazard;
    end

    always_comb begin
        inc = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            inc[r] = accept && op.rd_we && (op.rd == REG_ADDR_W'(r));
        end
    end

    assign count[0]     = '0;
    assign busy[0]      = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock       (clock),
            .reset       (reset),
            .inc         (inc[r]),
            .dec         (wb_hit[r]),
            .kill        (kill_hit[r]),
            .count_q     (count[r]),
            .busy_q      (busy[r]),
            .underflow_c (underflow[r])
        );
    end

    always_comb begin
        sb_error_d = sb_error_q || (|underflow);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_error_q <= 1'b0;
        end else begin
            sb_error_q <= sb_error_d;
        end
    end

    assign sb.issue_accept = accept;
    assign sb.stall        = sb.issue_valid && !accept;
    assign sb.busy_mask    = busy;
    assign sb.sb_error     = sb_error_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: issue/writeback/kill sequences with hand-computed
// accept, stall, busy_mask and sb_error values.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_pass;

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        sb_if.issue_valid    = 1'b0;
        sb_if.issue_rs1      = '0;
        sb_if.issue_rs1_used = 1'b0;
        sb_if.issue_rs2      = '0;
        sb_if.issue_rs2_used = 1'b0;
        sb_if.issue_rd       = '0;
        sb_if.issue_rd_we    = 1'b0;
        sb_if.wb_valid       = 1'b0;
        sb_if.wb_rd          = '0;
        sb_if.kill_valid     = 1'b0;
        sb_if.kill_rd        = '0;
    endtask

    task automatic issue(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we);
        sb_if.issue_valid    = 1'b1;
        sb_if.issue_rs1      = REG_ADDR_W'(rs1);
        sb_if.issue_rs1_used = u1;
        sb_if.issue_rs2      = REG_ADDR_W'(rs2);
        sb_if.issue_rs2_used = u2;
        sb_if.issue_rd       = REG_ADDR_W'(rd);
        sb_if.issue_rd_we    = we;
    endtask

    task automatic wb(input int rd);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = REG_ADDR_W'(rd);
    endtask

    task automatic kill(input int rd);
        sb_if.kill_valid = 1'b1;
        sb_if.kill_rd    = REG_ADDR_W'(rd);
    endtask

    // Inputs change 1 time unit after a rising edge; combinational outputs are read 3 later.
    task automatic settle();
        #3;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clr();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        clr();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        settle();
        chk("reset_busy", sb_if.busy_mask, 32'h0);
        chk("reset_err", 32'(sb_if.sb_error), 32'h0);
        chk("idle_accept", 32'(sb_if.issue_accept), 32'h0);
        chk("idle_stall", 32'(sb_if.stall), 32'h0);
        tick();

        // RAW on r5 resolved by same-cycle writeback
        issue(0, 0, 0, 0, 5, 1);
        settle(); chk("t1_issue_rd5", 32'(sb_if.issue_accept), 32'h1);
        tick();   chk("t1_busy5", sb_if.busy_mask, 32'h0000_0020);
        issue(5, 1, 0, 0, 0, 0);
        settle(); chk("t1_raw_stall", 32'(sb_if.stall), 32'h1);
        wb(5);
        settle(); chk("t1_bypass_accept", 32'(sb_if.issue_accept), 32'h1);
        chk("t1_bypass_stall", 32'(sb_if.stall), 32'h0);
        tick();   chk("t1_busy_clear", sb_if.busy_mask, 32'h0);

        // Three writes to r7 fill the counter; the fourth waits for a writeback
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 0, 0, 7, 1);
            settle(); chk("t2_fill_accept", 32'(sb_if.issue_accept), 32'h1);
            tick();
        end
        chk("t2_busy7", sb_if.busy_mask, 32'h0000_0080);
        for (int i = 0; i < 2; i++) begin
            issue(0, 0, 0, 0, 7, 1);
            settle(); chk("t2_sat_stall", 32'(sb_if.stall), 32'h1);
            tick();
        end
        issue(0, 0, 0, 0, 7, 1);
        wb(7);
        settle(); chk("t2_sat_wb_accept", 32'(sb_if.issue_accept), 32'h1);
        tick();
        for (int i = 0; i < 2; i++) begin
            wb(7);
            tick();
        end
        chk("t2_still_busy", sb_if.busy_mask, 32'h0000_0080);
        wb(7);
        tick();   chk("t2_drained", sb_if.busy_mask, 32'h0);
        chk("t2_no_err", 32'(sb_if.sb_error), 32'h0);

        // Simultaneous issue, writeback and kill on r3
        issue(0, 0, 0, 0, 3, 1);
        tick();   chk("t3_busy3", sb_if.busy_mask, 32'h0000_0008);
        issue(0, 0, 0, 0, 3, 1); wb(3); kill(3);
        settle(); chk("t3_accept", 32'(sb_if.issue_accept), 32'h1);
        tick();   chk("t3_net_zero", sb_if.busy_mask, 32'h0);
        chk("t3_no_err", 32'(sb_if.sb_error), 32'h0);
        issue(0, 0, 0, 0, 3, 1); wb(3); kill(3);
        tick();   chk("t3_clamp", sb_if.busy_mask, 32'h0);
        chk("t3_underflow", 32'(sb_if.sb_error), 32'h1);
        tick();   chk("t3_sticky", 32'(sb_if.sb_error), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t3_err_reset", 32'(sb_if.sb_error), 32'h0);

        // Register 0 never tracked
        issue(0, 0, 0, 0, 0, 1);
        settle(); chk("t4_rd0_accept", 32'(sb_if.issue_accept), 32'h1);
        tick();   chk("t4_rd0_busy", sb_if.busy_mask, 32'h0);
        issue(0, 1, 0, 1, 0, 0);
        settle(); chk("t4_rs0_stall", 32'(sb_if.stall), 32'h0);
        tick();
        wb(0); kill(0);
        tick();   chk("t4_wb0_busy", sb_if.busy_mask, 32'h0);
        chk("t4_wb0_err", 32'(sb_if.sb_error), 32'h0);

        // Two pending sources, only one written back
        issue(0, 0, 0, 0, 4, 1);
        tick();
        issue(0, 0, 0, 0, 9, 1);
        tick();   chk("t5_busy", sb_if.busy_mask, 32'h0000_0210);
        issue(4, 1, 9, 1, 0, 0); wb(4);
        settle(); chk("t5_rs2_stall", 32'(sb_if.stall), 32'h1);
        tick();   chk("t5_busy9", sb_if.busy_mask, 32'h0000_0200);
        issue(4, 1, 9, 1, 0, 0); wb(9);
        settle(); chk("t5_accept", 32'(sb_if.issue_accept), 32'h1);
        tick();   chk("t5_clear", sb_if.busy_mask, 32'h0);

        // Kill does not resolve a source hazard in the same cycle
        issue(0, 0, 0, 0, 6, 1);
        tick();
        issue(6, 1, 0, 0, 0, 0); kill(6);
        settle(); chk("t5k_kill_stall", 32'(sb_if.stall), 32'h1);
        tick();   chk("t5k_killed", sb_if.busy_mask, 32'h0);
        issue(6, 1, 0, 0, 0, 0);
        settle(); chk("t5k_accept", 32'(sb_if.issue_accept), 32'h1);
        tick();

        // Reset mid-stream drops all pending state
        issue(0, 0, 0, 0, 2, 1);
        tick();
        issue(0, 0, 0, 0, 2, 1);
        tick();
        issue(0, 0, 0, 0, 11, 1);
        tick();   chk("t6_busy", sb_if.busy_mask, 32'h0000_0804);
        reset = 1'b1;
        issue(0, 0, 0, 0, 12, 1);
        tick();
        reset = 1'b0;
        chk("t6_reset_busy", sb_if.busy_mask, 32'h0);
        chk("t6_reset_err", 32'(sb_if.sb_error), 32'h0);
        wb(2);
        tick();   chk("t6_stray_err", 32'(sb_if.sb_error), 32'h1);
        chk("t6_stray_busy", sb_if.busy_mask, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Hazard scheduler for the 32x32 register file in the 5-stage pipeline.
- Tracks in-flight writes per architectural register between decode issue and writeback.
- Grants or withholds issue of the decoded instruction so that register-file reads never return stale data.
- Sits beside the decode stage: it consumes decoded rs1/rs2/rd, the writeback write enable/address and pipeline kill events, and drives the decode stall.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
ADDR_W, 5, register address width.
CNT_W, 2, width of the per-register pending-write counter; at most 2^CNT_W-1 writes in flight per register.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
issue_valid  in  1  decode presents an instruction this cycle.
issue_rs1  in  ADDR_W  source 1 address.
issue_rs1_used  in  1  instruction reads rs1.
issue_rs2  in  ADDR_W  source 2 address.
issue_rs2_used  in  1  instruction reads rs2.
issue_rd  in  ADDR_W  destination address.
issue_rd_we  in  1  instruction writes rd.
issue_accept  out  1  combinational; instruction advances this cycle.
stall  out  1  combinational; equals issue_valid & ~issue_accept.
wb_valid  in  1  register-file write occurs this cycle (same signal as the file's write strobe).
wb_rd  in  ADDR_W  writeback address.
kill_valid  in  1  an in-flight writing instruction is squashed this cycle.
kill_rd  in  ADDR_W  destination of the squashed instruction.
busy_mask  out  NUM_REGS  registered; bit r = 1 when count[r] != 0.
sb_error  out  1  registered, sticky; decrement seen on a zero counter.

Behaviour:
- State: count[1..NUM_REGS-1], CNT_W bits each. count[0] is constant 0 and is never incremented.
- Reset (synchronous, takes priority over all events): every count = 0, busy_mask = 0, sb_error = 0.
- Effective writeback: wb_hit(r) = wb_valid & (wb_rd == r) & (r != 0). Same rule for kill_hit(r).
- Same-cycle bypass for sources: the register file writes on the rising edge and reads on the falling edge, so a writeback in the current cycle is visible to the current decode read.
- Source hazard, for rsX used and rsX != 0:
  - count[rsX] > 1, or
  - count[rsX] == 1 and not wb_hit(rsX).
  - A kill does not clear a source hazard in the same cycle.
- Saturation hazard: issue_rd_we, issue_rd != 0, count[issue_rd] == max, and not wb_hit(issue_rd).
- issue_accept = issue_valid & no source hazard & no saturation hazard. No stall for WAW: writeback is in order.
- Next state per register r: count' = count + inc - wb_hit - kill_hit, with inc = issue_accept & issue_rd_we & (issue_rd == r) & (r != 0).
- All three events may hit the same r in one cycle; the net change is applied, so +1-1-1 gives -1.
- Underflow: if the net change would drop below 0, clamp the counter at 0 and set sb_error. sb_error clears only on reset.
- Latency: a register issued with rd_we in cycle N shows busy_mask set in N+1. A dependent instruction stalls from N+1 until the cycle its writeback occurs, and is accepted in that writeback cycle.
- wb_rd == 0 or kill_rd == 0: ignored, no error.
- Reset mid-operation: all pending state is discarded. The pipeline is reset in the same cycle, so no stale writebacks follow.

Decomposition:
- Shared pipeline package holds:
  - REG_ADDR_W = 5 and NUM_REGS = 32.
  - ZERO_REG = 0.
  - A typedef for a decoded-operand bundle (rs1, rs1_used, rs2, rs2_used, rd, rd_we), also used by the decode stage.
- One natural sub-module, sb_counter: a single register's saturating up/down counter with inc/dec/kill inputs, a zero-clamp and an underflow flag. Instantiate it NUM_REGS-1 times; the top holds the hazard compare logic and the OR-reduction of the error flags.

Test Plan:
1. Reset, then issue rd=5 with rd_we -> accept=1; next cycle busy_mask=0x00000020. Issue rs1=5 -> stall=1; assert wb_valid, wb_rd=5 in the same cycle -> accept=1; next cycle busy_mask=0.
2. Issue three writes to rd=7 in consecutive cycles -> count=3. A fourth write to rd=7 -> stall=1 until wb_rd=7, then accept in that writeback cycle.
3. rd=3 pending (count=1); same cycle issue rd=3, wb_rd=3, kill_rd=3 -> count becomes 0, sb_error stays 0. Repeat with count=0 -> count stays 0, sb_error=1.
4. Issue rd=0 with rd_we, then rs1=0 used -> no stall, busy_mask bit0 always 0. wb_rd=0 and kill_rd=0 -> no state change, no error.
5. rs1=4, rs2=9 both pending with count=1; wb_rd=4 only -> stall=1. Next cycle wb_rd=9 -> accept=1.
6. Load several pending writes, pulse reset for one cycle mid-stream -> busy_mask=0 and sb_error=0 on the next cycle; a subsequent stray wb_rd=2 sets sb_error=1.
